sequential_mult: RTL and testbench
==================================

// Module: sequential_mult
// PURPOSE
//   Sequential shift-add multiplier; the inverse operation of the sequential divider.
//   Scales a 16-bit count by an 8-bit unsigned fraction (Q0.8):
//     product = floor(frac * mcand / 256).
//   Used in the synth datapath to turn a quotient back into a count (period/amplitude scaling).
//   One multiplier bit is processed per clock; the result is held until the next accepted start.
// PARAMETERS
//   WA   8    width of frac (fractional multiplier, Q0.WA)
//   WB   16   width of mcand and product
// PORTS
//   clk      in   1    system clock, rising edge
//   nrst     in   1    synchronous active-low reset, sampled on rising clk
//   start    in   1    request; sampled only in IDLE or DONE
//   frac     in   WA   fractional multiplier, unsigned, captured when start is accepted
//   mcand    in   WB   multiplicand, unsigned, captured when start is accepted
//   product  out  WB   registered result, floor(frac*mcand / 2^WA)
//   busy     out  1    high in LOAD and MULT
//   done     out  1    high while in DONE (level, not pulse)
// BEHAVIOUR
//   Reset (nrst==0 at a rising edge):
//     - state=IDLE; product=0, busy=0, done=0.
//     - Internal acc, operand and iteration registers all cleared.
//     - Reset applies mid-operation too: the in-flight result is discarded and product returns to 0.
//   FSM states: IDLE, LOAD, MULT, DONE.
//     IDLE -> LOAD  when start=1; frac and mcand are registered on that edge.
//     LOAD -> MULT  unconditionally; acc (WA+WB bits) <= 0 and iter <= 0.
//     MULT -> MULT  while iter != WA-1.
//     MULT -> DONE  when iter == WA-1 (WA cycles in MULT).
//     DONE -> LOAD  when start=1, capturing new operands; otherwise stay in DONE.
//   MULT step (LSB-first):
//     - If A[0]: upper = acc[WA+WB-1:WA] + B, WB+1 bits wide with carry kept.
//       Else: upper = acc[WA+WB-1:WA], zero-extended to WB+1 bits.
//     - acc <= {upper, acc[WA-1:0]} >> 1; A <= A >> 1; iter <= iter + 1.
//     - After WA steps acc holds the exact frac*mcand (WA+WB bits); no overflow is possible.
//   Output:
//     - product <= acc[WA+WB-1:WA] on the same edge that enters DONE.
//     - product holds that value until the next MULT->DONE transition or reset.
//     - product is not cleared when a new start is accepted.
//   Latency:
//     - start sampled at edge k.
//     - LOAD after edge k; MULT after edges k+1..k+WA; DONE/product valid after edge k+WA+1.
//     - Default parameters: 9 cycles.
//   Boundary conditions:
//     - start during LOAD or MULT is ignored; operands are not re-captured.
//     - start held high continuously gives back-to-back operations: DONE lasts 1 cycle, then LOAD.
//     - frac=0 or mcand=0 -> product=0, with the same latency (no early exit).
//     - Maximum frac=2^WA-1 with mcand=2^WB-1 -> no wrap; the result is truncated, never rounded.
//     - Input changes outside the capture edge have no effect.
// TESTING
//   1. Reset: nrst low 2 cycles with start=1 -> product=0, busy=0, done=0, state IDLE.
//   2. frac=0x80, mcand=1000, start 1 cycle -> busy for 9 cycles, then done=1, product=500.
//   3. frac=0xFF, mcand=0xFFFF -> product=65279; frac=0x40, mcand=0x0300 -> product=192.
//   4. frac=0x00, mcand=0xFFFF -> product=0 after exactly 9 cycles;
//      then frac=0x01, mcand=0x00FF -> product=0 (truncation).
//   5. Start with frac=0x80, mcand=200, pulse start again at MULT cycle 3 with frac=0xFF
//      -> second start ignored, product=100.
//   6. Start an operation, drop nrst at MULT cycle 4 -> IDLE, product=0;
//      next start (0x80, 64) -> product=32.
//      Then hold start high -> DONE lasts 1 cycle per result; each result valid.

Source files
------------

// File: rtl/sequential_mult.sv
// Sequential shift-add multiplier: product = floor(frac * mcand / 2^WA), frac in Q0.WA.
// One multiplier bit per clock, LSB first; the result is held until the next completion.
module sequential_mult #(
  parameter int WA = 8,
  parameter int WB = 16
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          start,
  input  logic [WA-1:0] frac,
  input  logic [WB-1:0] mcand,
  output logic [WB-1:0] product,
  output logic          busy,
  output logic          done
);

  localparam int AW = WA + WB;
  localparam int IW = (WA > 1) ? $clog2(WA) : 1;
  localparam logic [IW-1:0] ITER_LAST = IW'(WA - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MULT = 2'd2,
    DONE = 2'd3
  } state_t;

  // One shift-add step: add B into the upper half (carry kept), then shift right by one.
  function automatic logic [AW-1:0] shift_add_step(
    input logic [AW-1:0] acc,
    input logic          add,
    input logic [WB-1:0] b
  );
    logic [WB:0] upper;
    if (add) begin
      upper = {1'b0, acc[AW-1:WA]} + {1'b0, b};
    end else begin
      upper = {1'b0, acc[AW-1:WA]};
    end
    return {upper, acc[WA-1:1]};
  endfunction

  state_t          state_r;
  state_t          state_next_s;
  logic [WA-1:0]   a_r;
  logic [WB-1:0]   b_r;
  logic [AW-1:0]   acc_r;
  logic [AW-1:0]   acc_step_s;
  logic [IW-1:0]   iter_r;
  logic [WB-1:0]   product_r;
  logic            busy_r;
  logic            done_r;
  logic            capture_s;
  logic            finish_s;

  // Next-state decode, operand capture and completion strobes.
  always_comb begin
    state_next_s = state_r;
    capture_s    = 1'b0;
    finish_s     = 1'b0;
    acc_step_s   = shift_add_step(acc_r, a_r[0], b_r);
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_next_s = LOAD;
          capture_s    = 1'b1;
        end else begin
          state_next_s = state_r;
        end
      end
      LOAD: begin
        state_next_s = MULT;
      end
      MULT: begin
        if (iter_r == ITER_LAST) begin
          state_next_s = DONE;
          finish_s     = 1'b1;
        end else begin
          state_next_s = MULT;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_r   <= IDLE;
      a_r       <= {WA{1'b0}};
      b_r       <= {WB{1'b0}};
      acc_r     <= {AW{1'b0}};
      iter_r    <= {IW{1'b0}};
      product_r <= {WB{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      case (state_r)
        IDLE, DONE: begin
          if (capture_s) begin
            a_r <= frac;
            b_r <= mcand;
          end else begin
            a_r <= a_r;
            b_r <= b_r;
          end
        end
        LOAD: begin
          acc_r  <= {AW{1'b0}};
          iter_r <= {IW{1'b0}};
        end
        MULT: begin
          acc_r  <= acc_step_s;
          a_r    <= {1'b0, a_r[WA-1:1]};
          iter_r <= iter_r + IW'(1);
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
      // Last step's result goes straight to the output on the edge that enters DONE.
      if (finish_s) begin
        product_r <= acc_step_s[AW-1:WA];
      end else begin
        product_r <= product_r;
      end
      busy_r <= (state_next_s == LOAD) || (state_next_s == MULT);
      done_r <= (state_next_s == DONE);
    end
  end

  assign product = product_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_sequential_mult.sv
// Directed self-checking bench for sequential_mult (WA=8, WB=16).
module tb_sequential_mult;

  logic        clk;
  logic        nrst;
  logic        start;
  logic [7:0]  frac;
  logic [15:0] mcand;
  logic [15:0] product;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int cnt;
  logic [15:0] last_exp;

  logic [7:0]  bb_frac [4] = '{8'hFF, 8'h40, 8'h03, 8'h11};
  logic [15:0] bb_mcand[4] = '{16'hFFFF, 16'h0300, 16'h1234, 16'h2222};
  logic [15:0] bb_exp  [3] = '{16'd65279, 16'd192, 16'd54};

  sequential_mult #(.WA(8), .WB(16)) dut (
    .clk(clk), .nrst(nrst), .start(start), .frac(frac),
    .mcand(mcand), .product(product), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Launch one operation, scramble inputs while busy, check latency and result.
  task automatic run_op(input string tag, input logic [7:0] f, input logic [15:0] m,
                        input logic [15:0] exp);
    frac = f; mcand = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (busy && cnt < 20) begin
      cnt++;
      if (cnt == 1) check_val({tag, "_hold"}, product, last_exp);
      frac = 8'($urandom); mcand = 16'($urandom);
      @(negedge clk);
    end
    check_val({tag, "_lat"}, cnt, 9);
    check_val({tag, "_done"}, done, 1);
    check_val({tag, "_prod"}, product, exp);
    last_exp = exp;
  endtask

  initial begin
    // 1. reset with start asserted
    nrst = 1'b0; start = 1'b1; frac = 8'h80; mcand = 16'd5;
    last_exp = 16'd0;
    repeat (2) @(negedge clk);
    check_val("rst_prod", product, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    nrst = 1'b1; start = 1'b0;
    @(negedge clk);
    check_val("idle_busy", busy, 0);
    check_val("idle_done", done, 0);

    // 2-4. basic products and boundaries
    run_op("half", 8'h80, 16'd1000, 16'd500);
    run_op("max", 8'hFF, 16'hFFFF, 16'd65279);
    run_op("q25", 8'h40, 16'h0300, 16'd192);
    run_op("fzero", 8'h00, 16'hFFFF, 16'd0);
    run_op("trunc", 8'h01, 16'h00FF, 16'd0);
    run_op("mzero", 8'hFF, 16'h0000, 16'd0);
    run_op("q75", 8'hC0, 16'd1000, 16'd750);

    // 5. start during MULT is ignored
    frac = 8'h80; mcand = 16'd200; start = 1'b1;
    @(negedge clk);
    cnt = 0;
    while (busy && cnt < 20) begin
      cnt++;
      if (cnt == 4) begin
        start = 1'b1; frac = 8'hFF; mcand = 16'hFFFF;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check_val("ign_lat", cnt, 9);
    check_val("ign_prod", product, 100);
    repeat (2) @(negedge clk);
    check_val("ign_done_lvl", done, 1);
    check_val("ign_prod_hold", product, 100);
    last_exp = 16'd100;

    // 6. reset in MULT cycle 4 discards the operation
    frac = 8'hFF; mcand = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check_val("mid_busy_pre", busy, 1);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    check_val("mid_prod", product, 0);
    check_val("mid_busy", busy, 0);
    check_val("mid_done", done, 0);
    @(negedge clk);
    check_val("mid_idle", busy, 0);
    last_exp = 16'd0;
    run_op("post", 8'h80, 16'd64, 16'd32);

    // back-to-back with start held high
    frac = bb_frac[0]; mcand = bb_mcand[0]; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("bb_done1", done, 0);
      cnt = 0;
      while (busy && cnt < 20) begin
        cnt++;
        frac = 8'($urandom); mcand = 16'($urandom);
        @(negedge clk);
      end
      check_val("bb_lat", cnt, 9);
      check_val("bb_done", done, 1);
      check_val("bb_prod", product, bb_exp[i]);
      frac = bb_frac[i+1]; mcand = bb_mcand[i+1];
    end
    start = 1'b0;
    @(negedge clk);
    check_val("bb_end_done", done, 1);
    check_val("bb_end_prod", product, 54);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
